// File: rtl/group_dedup_pkg.sv
// group_dedup_pkg: shared FSM encoding, default geometry and width helpers
// for the group_dedup block and its interface.
package group_dedup_pkg;

  localparam int DEF_GROUP_SIZE     = 4;
  localparam int DEF_LOG_GROUP_SIZE = 2;
  localparam int DEF_DATA_WIDTH     = 16;
  localparam int DEF_LOG_MAX_GROUPS = 16;

  // info carries the mask row plus the upper equality rows
  localparam int INFO_WIDTH = DEF_GROUP_SIZE * DEF_GROUP_SIZE;
  localparam int OUT_WIDTH  = DEF_DATA_WIDTH + INFO_WIDTH;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_CMP     = 2'd2;
  localparam logic [1:0] S_EMIT    = 2'd3;

  function automatic int info_width(input int gs);
    return gs * gs;
  endfunction

  function automatic int out_width(input int dw, input int gs);
    return dw + info_width(gs);
  endfunction

endpackage

// File: rtl/group_dedup_if.sv
// group_dedup_if: configuration, upstream and downstream handshake bundle.
// master = the side feeding values / consuming emissions, slave = group_dedup.
interface group_dedup_if
  import group_dedup_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int GROUP_SIZE     = DEF_GROUP_SIZE,
  parameter int LOG_MAX_GROUPS = DEF_LOG_MAX_GROUPS
);

  logic                                      configure;
  logic [LOG_MAX_GROUPS-1:0]                 num_groups;
  logic [DATA_WIDTH-1:0]                     data_in;
  logic                                      valid_in;
  logic                                      avail_out;
  logic [out_width(DATA_WIDTH, GROUP_SIZE)-1:0] data_out;
  logic                                      valid_out;
  logic                                      avail_in;

  modport master (
    output configure, num_groups, data_in, valid_in, avail_in,
    input  avail_out, data_out, valid_out
  );

  modport slave (
    input  configure, num_groups, data_in, valid_in, avail_in,
    output avail_out, data_out, valid_out
  );

endinterface

// File: rtl/group_dedup_eq_matrix.sv
// group_dedup_eq_matrix: all-against-all equality of one buffered group.
// eq[i*GROUP_SIZE + j] is set when value i equals value j (diagonal always 1).
module group_dedup_eq_matrix
  import group_dedup_pkg::*;
#(
  parameter int GROUP_SIZE = DEF_GROUP_SIZE,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic [GROUP_SIZE*DATA_WIDTH-1:0] vals,
  output logic [GROUP_SIZE*GROUP_SIZE-1:0] eq
);

  // full comparator array, purely combinational
  always_comb begin
    eq = '0;
    for (int i = 0; i < GROUP_SIZE; i++) begin
      for (int j = 0; j < GROUP_SIZE; j++) begin
        eq[i*GROUP_SIZE + j] = (vals[i*DATA_WIDTH +: DATA_WIDTH] ==
                                vals[j*DATA_WIDTH +: DATA_WIDTH]);
      end
    end
  end

endmodule

// File: rtl/group_dedup.sv
// group_dedup: collects GROUP_SIZE values, registers their equality matrix,
// then emits {info, value} entries in lowest-index-first order.
// Build option GROUP_DEDUP_MERGE_EN: when defined, each emission covers every
// still-pending duplicate of the chosen value; when undefined, every element
// is emitted on its own (one-hot mask, GROUP_SIZE emissions per group).
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | no work; waits for configure
// S_COLLECT | accepting values into slots 0..GROUP_SIZE-1
// S_CMP     | latch equality matrix, arm pending mask
// S_EMIT    | present lowest pending element until all pending cleared
module group_dedup
  import group_dedup_pkg::*;
#(
  parameter int GROUP_SIZE     = DEF_GROUP_SIZE,
  parameter int LOG_GROUP_SIZE = DEF_LOG_GROUP_SIZE,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int LOG_MAX_GROUPS = DEF_LOG_MAX_GROUPS
) (
  input logic          clk,
  input logic          rst,
  group_dedup_if.slave bus
);

  localparam int INFO_W = info_width(GROUP_SIZE);

  logic [1:0]                      state;
  logic [LOG_GROUP_SIZE-1:0]       idx;
  logic [DATA_WIDTH-1:0]           vals [GROUP_SIZE];
  logic [GROUP_SIZE-1:0]           eq_q [GROUP_SIZE];
  logic [GROUP_SIZE-1:0]           pending;
  logic [LOG_MAX_GROUPS-1:0]       grp_cnt;

  logic [GROUP_SIZE*DATA_WIDTH-1:0] vals_flat;
  logic [INFO_W-1:0]                eq_flat;
  logic [LOG_GROUP_SIZE-1:0]        p;
  logic [GROUP_SIZE-1:0]            mask;
  logic [GROUP_SIZE-1:0]            remaining;
  logic [INFO_W-1:0]                info;
  logic                             in_collect;
  logic                             in_emit;

  assign in_collect = (state == S_COLLECT);
  assign in_emit    = (state == S_EMIT);

  // flatten the value buffer for the comparator array
  always_comb begin
    vals_flat = '0;
    for (int i = 0; i < GROUP_SIZE; i++) begin
      vals_flat[i*DATA_WIDTH +: DATA_WIDTH] = vals[i];
    end
  end

  group_dedup_eq_matrix #(
    .GROUP_SIZE (GROUP_SIZE),
    .DATA_WIDTH (DATA_WIDTH)
  ) eq_matrix (
    .vals (vals_flat),
    .eq   (eq_flat)
  );

  // lowest set pending bit wins
  always_comb begin
    p = '0;
    for (int i = GROUP_SIZE - 1; i >= 0; i--) begin
      if (pending[i]) p = LOG_GROUP_SIZE'(i);
    end
  end

`ifdef GROUP_DEDUP_MERGE_EN
  // chosen element plus all its still-pending duplicates
  always_comb begin
    mask = eq_q[p] & pending;
  end
`else
  // only the chosen element itself
  always_comb begin
    mask    = '0;
    mask[p] = 1'b1;
  end
`endif

  assign remaining = pending & ~mask;

  // info = {E[GROUP_SIZE-1] .. E[1], mask}; row 0 slot is replaced by the mask
  always_comb begin
    info                   = '0;
    info[GROUP_SIZE-1:0]   = mask;
    for (int r = 1; r < GROUP_SIZE; r++) begin
      info[r*GROUP_SIZE +: GROUP_SIZE] = eq_q[r];
    end
  end

  assign bus.avail_out = in_collect;
  assign bus.valid_out = in_emit;
  assign bus.data_out  = in_emit ? {info, vals[p]} : '0;

  // sequencing FSM; configure overrides any accept or emission in the same cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_IDLE;
      idx     <= '0;
      pending <= '0;
      grp_cnt <= '0;
      for (int i = 0; i < GROUP_SIZE; i++) begin
        vals[i] <= '0;
        eq_q[i] <= '0;
      end
    end else if (bus.configure) begin
      state   <= S_COLLECT;
      idx     <= '0;
      pending <= '0;
      grp_cnt <= (bus.num_groups == '0) ? LOG_MAX_GROUPS'(1) : bus.num_groups;
      for (int i = 0; i < GROUP_SIZE; i++) begin
        vals[i] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
        end
        S_COLLECT: begin
          if (bus.valid_in) begin
            vals[idx] <= bus.data_in;
            if (idx == LOG_GROUP_SIZE'(GROUP_SIZE - 1)) begin
              idx   <= '0;
              state <= S_CMP;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        S_CMP: begin
          for (int i = 0; i < GROUP_SIZE; i++) begin
            eq_q[i] <= eq_flat[i*GROUP_SIZE +: GROUP_SIZE];
          end
          pending <= '1;
          state   <= S_EMIT;
        end
        S_EMIT: begin
          if (bus.avail_in) begin
            pending <= remaining;
            if (remaining == '0) begin
              grp_cnt <= grp_cnt - 1'b1;
              state   <= (grp_cnt == LOG_MAX_GROUPS'(1)) ? S_IDLE : S_COLLECT;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_group_dedup.sv
// tb_group_dedup: directed scenarios for group_dedup with hand-computed
// {info, value} words. Inputs change and outputs are sampled on the falling edge.
module tb_group_dedup;
  import group_dedup_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  group_dedup_if #(.DATA_WIDTH(16), .GROUP_SIZE(4), .LOG_MAX_GROUPS(16)) bus ();

  group_dedup #(
    .GROUP_SIZE     (4),
    .LOG_GROUP_SIZE (2),
    .DATA_WIDTH     (16),
    .LOG_MAX_GROUPS (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic cfg(input logic [15:0] n);
    bus.configure  = 1'b1;
    bus.num_groups = n;
    @(negedge clk);
    bus.configure  = 1'b0;
  endtask

  // offers one value; returns on the falling edge right after it was accepted
  task automatic push(input logic [15:0] v);
    int n = 0;
    while (bus.avail_out !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.avail_out !== 1'b1) begin
      failures++;
      $display("FAIL push_wait avail_out=%b expected=1", bus.avail_out);
    end
    bus.valid_in = 1'b1;
    bus.data_in  = v;
    @(negedge clk);
    bus.valid_in = 1'b0;
  endtask

  task automatic test_reset();
    rst            = 1'b0;
    bus.valid_in   = 1'b1;
    bus.data_in    = 16'h1234;
    bus.configure  = 1'b1;
    bus.num_groups = 16'd3;
    bus.avail_in   = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.avail_out !== 1'b0) begin
      failures++; $display("FAIL reset_avail_out got=%b expected=0", bus.avail_out);
    end
    checks++;
    if (bus.valid_out !== 1'b0) begin
      failures++; $display("FAIL reset_valid_out got=%b expected=0", bus.valid_out);
    end
    checks++;
    if (bus.data_out !== 32'h0) begin
      failures++; $display("FAIL reset_data_out got=%h expected=0", bus.data_out);
    end
    bus.valid_in  = 1'b0;
    bus.configure = 1'b0;
    rst           = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.avail_out !== 1'b0) begin
      failures++; $display("FAIL reset_idle_avail got=%b expected=0", bus.avail_out);
    end
  endtask

  task automatic test_dedup_basic();
    logic [31:0] exp [$];
`ifdef GROUP_DEDUP_MERGE_EN
    exp = '{32'h8525_0005, 32'h8522_0007, 32'h8528_0009};
`else
    exp = '{32'h8521_0005, 32'h8522_0007, 32'h8524_0005, 32'h8528_0009};
`endif
    bus.avail_in = 1'b1;
    cfg(16'd1);
    push(16'd5); push(16'd7); push(16'd5); push(16'd9);
    checks++;
    if (bus.valid_out !== 1'b0) begin
      failures++; $display("FAIL basic_cmp_valid got=%b expected=0", bus.valid_out);
    end
    @(negedge clk);
    foreach (exp[k]) begin
      checks++;
      if (bus.valid_out !== 1'b1 || bus.data_out !== exp[k]) begin
        failures++;
        $display("FAIL basic_emit%0d valid=%b data=%h expected=%h", k, bus.valid_out, bus.data_out, exp[k]);
      end
      checks++;
      if (bus.avail_out !== 1'b0) begin
        failures++; $display("FAIL basic_avail_in_emit got=%b expected=0", bus.avail_out);
      end
      @(negedge clk);
    end
    checks++;
    if (bus.valid_out !== 1'b0 || bus.avail_out !== 1'b0) begin
      failures++;
      $display("FAIL basic_idle valid=%b avail=%b expected 0 0", bus.valid_out, bus.avail_out);
    end
    bus.valid_in = 1'b1;
    bus.data_in  = 16'hAAAA;
    repeat (3) @(negedge clk);
    bus.valid_in = 1'b0;
    checks++;
    if (bus.valid_out !== 1'b0 || bus.avail_out !== 1'b0) begin
      failures++;
      $display("FAIL idle_ignores_valid valid=%b avail=%b expected 0 0", bus.valid_out, bus.avail_out);
    end
  endtask

  // num_groups of 0 behaves as a single group
  task automatic test_all_equal();
    logic [31:0] exp [$];
`ifdef GROUP_DEDUP_MERGE_EN
    exp = '{32'hFFFF_0003};
`else
    exp = '{32'hFFF1_0003, 32'hFFF2_0003, 32'hFFF4_0003, 32'hFFF8_0003};
`endif
    bus.avail_in = 1'b1;
    cfg(16'd0);
    push(16'd3); push(16'd3); push(16'd3); push(16'd3);
    @(negedge clk);
    foreach (exp[k]) begin
      checks++;
      if (bus.valid_out !== 1'b1 || bus.data_out !== exp[k]) begin
        failures++;
        $display("FAIL equal_emit%0d valid=%b data=%h expected=%h", k, bus.valid_out, bus.data_out, exp[k]);
      end
      @(negedge clk);
    end
    checks++;
    if (bus.valid_out !== 1'b0 || bus.avail_out !== 1'b0) begin
      failures++;
      $display("FAIL equal_zero_groups_idle valid=%b avail=%b expected 0 0", bus.valid_out, bus.avail_out);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] vals [8];
    logic [31:0] exp [$];
    logic [31:0] prev_data = '0;
    logic        v;
    logic [31:0] d;
    int          k = 0;
    int          in_i = 0;
    bit          tog = 1'b1;
    bit          prev_stall = 1'b0;
    vals = '{16'd5, 16'd7, 16'd5, 16'd9, 16'd1, 16'd2, 16'd3, 16'd4};
`ifdef GROUP_DEDUP_MERGE_EN
    exp = '{32'h8525_0005, 32'h8522_0007, 32'h8528_0009,
            32'h8421_0001, 32'h8422_0002, 32'h8424_0003, 32'h8428_0004};
`else
    exp = '{32'h8521_0005, 32'h8522_0007, 32'h8524_0005, 32'h8528_0009,
            32'h8421_0001, 32'h8422_0002, 32'h8424_0003, 32'h8428_0004};
`endif
    cfg(16'd2);
    for (int c = 0; c < 150 && k < exp.size(); c++) begin
      v = bus.valid_out;
      d = bus.data_out;
      if (prev_stall) begin
        checks++;
        if (v !== 1'b1 || d !== prev_data) begin
          failures++;
          $display("FAIL bp_hold valid=%b data=%h expected=%h", v, d, prev_data);
        end
      end
      if (v === 1'b1) begin
        checks++;
        if (bus.avail_out !== 1'b0) begin
          failures++; $display("FAIL bp_avail_in_emit got=%b expected=0", bus.avail_out);
        end
      end
      if (bus.avail_out === 1'b1 && in_i < 8) begin
        bus.valid_in = 1'b1;
        bus.data_in  = vals[in_i];
        in_i++;
      end else begin
        bus.valid_in = 1'b0;
      end
      bus.avail_in = tog;
      tog = ~tog;
      if (v === 1'b1 && bus.avail_in) begin
        checks++;
        if (d !== exp[k]) begin
          failures++; $display("FAIL bp_emit%0d data=%h expected=%h", k, d, exp[k]);
        end
        k++;
      end
      prev_stall = (v === 1'b1) && !bus.avail_in;
      prev_data  = d;
      @(negedge clk);
    end
    bus.valid_in = 1'b0;
    bus.avail_in = 1'b1;
    checks++;
    if (k != exp.size()) begin
      failures++; $display("FAIL bp_count got=%0d expected=%0d", k, exp.size());
    end
    checks++;
    if (bus.valid_out !== 1'b0 || bus.avail_out !== 1'b0) begin
      failures++;
      $display("FAIL bp_idle valid=%b avail=%b expected 0 0", bus.valid_out, bus.avail_out);
    end
  endtask

  task automatic test_cfg_in_emit();
    logic [31:0] exp [$];
`ifdef GROUP_DEDUP_MERGE_EN
    exp = '{32'hFFFF_0003};
`else
    exp = '{32'hFFF1_0003, 32'hFFF2_0003, 32'hFFF4_0003, 32'hFFF8_0003};
`endif
    bus.avail_in = 1'b0;
    cfg(16'd1);
    push(16'd1); push(16'd2); push(16'd3); push(16'd4);
    @(negedge clk);
    checks++;
    if (bus.valid_out !== 1'b1 || bus.data_out !== 32'h8421_0001) begin
      failures++;
      $display("FAIL cfgemit_stalled valid=%b data=%h expected=84210001", bus.valid_out, bus.data_out);
    end
    bus.configure  = 1'b1;
    bus.num_groups = 16'd1;
    bus.avail_in   = 1'b1;
    @(negedge clk);
    bus.configure  = 1'b0;
    checks++;
    if (bus.valid_out !== 1'b0 || bus.data_out !== 32'h0) begin
      failures++;
      $display("FAIL cfgemit_cleared valid=%b data=%h expected 0", bus.valid_out, bus.data_out);
    end
    checks++;
    if (bus.avail_out !== 1'b1) begin
      failures++; $display("FAIL cfgemit_collect avail=%b expected=1", bus.avail_out);
    end
    push(16'd3); push(16'd3); push(16'd3); push(16'd3);
    @(negedge clk);
    foreach (exp[k]) begin
      checks++;
      if (bus.valid_out !== 1'b1 || bus.data_out !== exp[k]) begin
        failures++;
        $display("FAIL cfgemit_emit%0d valid=%b data=%h expected=%h", k, bus.valid_out, bus.data_out, exp[k]);
      end
      @(negedge clk);
    end
    checks++;
    if (bus.valid_out !== 1'b0 || bus.avail_out !== 1'b0) begin
      failures++;
      $display("FAIL cfgemit_idle valid=%b avail=%b expected 0 0", bus.valid_out, bus.avail_out);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp [$];
`ifdef GROUP_DEDUP_MERGE_EN
    exp = '{32'h8525_0005, 32'h8522_0007, 32'h8528_0009};
`else
    exp = '{32'h8521_0005, 32'h8522_0007, 32'h8524_0005, 32'h8528_0009};
`endif
    bus.avail_in = 1'b1;
    cfg(16'd1);
    push(16'd9); push(16'd9);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.avail_out !== 1'b0 || bus.valid_out !== 1'b0 || bus.data_out !== 32'h0) begin
      failures++;
      $display("FAIL midrst_outputs avail=%b valid=%b data=%h expected all 0",
               bus.avail_out, bus.valid_out, bus.data_out);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.avail_out !== 1'b0) begin
      failures++; $display("FAIL midrst_idle avail=%b expected=0", bus.avail_out);
    end
    cfg(16'd1);
    push(16'd5); push(16'd7); push(16'd5); push(16'd9);
    @(negedge clk);
    foreach (exp[k]) begin
      checks++;
      if (bus.valid_out !== 1'b1 || bus.data_out !== exp[k]) begin
        failures++;
        $display("FAIL midrst_emit%0d valid=%b data=%h expected=%h", k, bus.valid_out, bus.data_out, exp[k]);
      end
      @(negedge clk);
    end
    checks++;
    if (bus.valid_out !== 1'b0) begin
      failures++; $display("FAIL midrst_done valid=%b expected=0", bus.valid_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp [4];
    exp = '{32'h8421_0001, 32'h8422_0002, 32'h8424_0003, 32'h8428_0004};
    bus.avail_in = 1'b1;
    cfg(16'd1);
    push(16'd1); push(16'd2); push(16'd3); push(16'd4);
    checks++;
    if (bus.valid_out !== 1'b0) begin
      failures++; $display("FAIL b2b_latency_early valid=%b expected=0", bus.valid_out);
    end
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bus.valid_out !== 1'b1 || bus.data_out !== exp[k]) begin
        failures++;
        $display("FAIL b2b_emit%0d valid=%b data=%h expected=%h", k, bus.valid_out, bus.data_out, exp[k]);
      end
      @(negedge clk);
    end
    checks++;
    if (bus.valid_out !== 1'b0 || bus.avail_out !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle valid=%b avail=%b expected 0 0", bus.valid_out, bus.avail_out);
    end
  endtask

  initial begin
    rst            = 1'b0;
    bus.configure  = 1'b0;
    bus.num_groups = '0;
    bus.data_in    = '0;
    bus.valid_in   = 1'b0;
    bus.avail_in   = 1'b1;
    test_reset();
    test_dedup_basic();
    test_all_equal();
    test_backpressure();
    test_cfg_in_emit();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
